gessm_mult_pipe: RTL and testbench
==================================

Name: gessm_mult_pipe

Overview:
- Parametrised, pipelined successor of the gESSM approximate segmented multiplier.
- Each N-bit operand is reduced to an M-bit window: low, mid (offset Q) or high. The M×M product is then shifted back into place.
- Adds selectable signed/unsigned mode per transaction, valid/ready handshake with backpressure, a tag passthrough, and an exactness flag.
- Sits between operand producers and accumulator/datapath consumers in the approximate-arithmetic datapath.

Parameters:
- N, 16, operand width.
- M, 8, segment width (multiplier core is M×M).
- Q, 5, mid-window offset. Legal only if 0 < Q < N-M and M+Q <= N; otherwise elaboration error.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  N  operand A.
- in_b  in  N  operand B.
- in_signed  in  1  1 = two's-complement operands; 0 = unsigned.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_ris  out  2N  approximate product.
- out_tag  out  TAG_W  tag of this result.
- out_exact  out  1  both operands used the low window.

Behaviour:
- Reset: clk and rst only; rst is asynchronous and active-high. While rst is high, all stage valids are 0, out_valid=0, out_ris=0, out_tag=0 and out_exact=0. Pipeline data registers also clear.
- Handshake: advance = !out_valid || out_ready. in_ready = advance. An input transfers on in_valid && in_ready.
  - All three stages shift together on advance and hold otherwise (global stall; bubbles are not compressed).
  - Output holds stable while out_valid && !out_ready.
- Latency: exactly 3 cycles from accepted input to out_valid, with no stalls. Throughput is 1 per cycle.
- Stage 1 (magnitude and segmentation, per operand):
  - mag = (in_signed && x[N-1]) ? -x : x, as an N-bit unsigned value. -2^(N-1) maps to 2^(N-1).
  - Segment selection:
    - HIGH if any of mag[N-1:M+Q] is set: window mag[N-1:N-M], shift N-M.
    - Else MID if any of mag[M+Q-1:M] is set: window mag[M+Q-1:Q], shift Q.
    - Else LOW: window mag[M-1:0], shift 0.
  - neg = in_signed && (a[N-1] ^ b[N-1]).
  - Register windows, shift codes, neg, tag and exact = (segA==LOW && segB==LOW).
- Stage 2: unsigned M×M product (2M bits), registered with the sideband fields.
- Stage 3:
  - res = zero-extend(product) << (shiftA+shiftB), 2N bits; no overflow is possible.
  - out_ris = neg ? (-res mod 2^2N) : res.
  - A zero operand yields 0 with no sign issue (-0 = 0).
- Reset asserted mid-operation discards all in-flight operations. No output is produced for them after release.
- The in_signed/in_tag values that travel with an operation are those sampled at its acceptance.

Decomposition:
- Package gessm_pkg holds:
  - segment enum SEG_LOW/SEG_MID/SEG_HIGH (2 bits);
  - function seg_shift(seg, N, M, Q);
  - parameter-legality check function.
- Sub-module gessm_segment: combinational per-operand magnitude, segment select and window extraction. Instantiated twice in stage 1.

Test Plan:
- Unsigned low/low: a=200, b=100, signed=0, tag=3 -> after 3 cycles out_ris=0x00004E20 (20000), out_tag=3, out_exact=1.
- Unsigned mid/low: a=0x1234, b=3 -> window 145, product 435<<5 -> out_ris=13920 (0x3660), out_exact=0.
- Unsigned high/high: a=0xFFFF, b=0xFFFF -> out_ris=0xFE010000.
- Signed negation: a=0xFF38 (-200), b=100, signed=1 -> out_ris=0xFFFFB1E0.
- Signed most-negative: a=0x8000, b=0x8000, signed=1 -> out_ris=0x40000000, out_exact=0.
- Backpressure and reset:
  - Stream 5 back-to-back ops with out_ready=0 after the first result -> out_valid, out_ris and in_ready=0 hold stable. Releasing out_ready drains results in order with correct tags.
  - Asserting rst mid-stream -> out_valid=0 immediately, and no stale result appears after release.

Source files
------------

// File: rtl/gessm_pkg.sv
// gessm_pkg: shared types and helpers for the gESSM pipelined multiplier.
//   seg_e          - which M-bit window of an operand feeds the core
//   seg_shift()    - left shift that puts a window's product bits back in place
//   params_legal() - elaboration-time sanity check of the N/M/Q geometry
package gessm_pkg;

    typedef enum logic [1:0] {
        SEG_LOW  = 2'd0,
        SEG_MID  = 2'd1,
        SEG_HIGH = 2'd2
    } seg_e;

    localparam int NUM_OPERANDS = 2;

    // A window taken from bit position k contributes its product k bits up.
    function automatic int seg_shift(input seg_e seg, input int n, input int m, input int q);
        int sh;
        sh = 0;
        case (seg)
            SEG_HIGH: sh = n - m;
            SEG_MID:  sh = q;
            default:  sh = 0;
        endcase
        return sh;
    endfunction

    // The mid window must sit strictly between the low and high windows,
    // otherwise segment selection becomes ambiguous or indexes out of range.
    function automatic bit params_legal(input int n, input int m, input int q);
        return (q > 0) && (q < n - m) && (m + q <= n);
    endfunction

endpackage

// File: rtl/gessm_segment.sv
// gessm_segment: combinational per-operand front end.
//   i_x      [N-1:0]  raw operand
//   i_signed          1 = treat i_x as two's complement
//   o_win    [M-1:0]  selected M-bit window of |i_x|
//   o_seg             which window was selected (sets the later shift)
// The magnitude of the most negative value wraps to 2^(N-1), which is still
// representable as an N-bit unsigned number, so no extra bit is needed.
module gessm_segment
    import gessm_pkg::*;
#(
    parameter int N = 16,
    parameter int M = 8,
    parameter int Q = 5
) (
    input  logic [N-1:0] i_x,
    input  logic         i_signed,
    output logic [M-1:0] o_win,
    output seg_e         o_seg
);

    logic [N-1:0] w_mag;
    logic         w_any_high;
    logic         w_any_mid;

    always_comb begin
        w_mag      = (i_signed && i_x[N-1]) ? (-i_x) : i_x;
        w_any_high = |w_mag[N-1:M+Q];
        w_any_mid  = |w_mag[M+Q-1:M];
    end

    // Priority: the highest populated window wins so the leading one is kept.
    always_comb begin
        o_win = w_mag[M-1:0];
        o_seg = SEG_LOW;
        if (w_any_high) begin
            o_win = w_mag[N-1:N-M];
            o_seg = SEG_HIGH;
        end else if (w_any_mid) begin
            o_win = w_mag[M+Q-1:Q];
            o_seg = SEG_MID;
        end
    end

endmodule

// File: rtl/gessm_mult_pipe.sv
// gessm_mult_pipe: three-stage pipelined approximate segmented multiplier.
//   clk, rst                  clock (rising edge), async active-high reset
//   in_valid/in_ready         operand handshake
//   in_a, in_b     [N-1:0]    operands
//   in_signed                 1 = two's-complement operands
//   in_tag     [TAG_W-1:0]    sideband returned with the result
//   out_valid/out_ready       result handshake
//   out_ris    [2N-1:0]       approximate product
//   out_tag    [TAG_W-1:0]    tag of this result
//   out_exact                 both operands fit the low window (result exact)
// Stage 1: magnitude + window select; stage 2: MxM product; stage 3: shift
// back into place and apply the sign. All stages move together on advance.
module gessm_mult_pipe
    import gessm_pkg::*;
#(
    parameter int N     = 16,
    parameter int M     = 8,
    parameter int Q     = 5,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_ris,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_exact
);

    generate
        if (!params_legal(N, M, Q)) begin : g_bad_params
            $error("gessm_mult_pipe: illegal geometry N=%0d M=%0d Q=%0d", N, M, Q);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Global stall: the whole pipe moves only when the output slot frees.
    // ------------------------------------------------------------------
    logic w_advance;
    logic r_out_valid;

    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;

    // ------------------------------------------------------------------
    // Stage 1 front end: one segment unit per operand.
    // ------------------------------------------------------------------
    logic [N-1:0] w_op  [NUM_OPERANDS];
    logic [M-1:0] w_win [NUM_OPERANDS];
    seg_e         w_seg [NUM_OPERANDS];

    assign w_op[0] = in_a;
    assign w_op[1] = in_b;

    generate
        for (genvar gi = 0; gi < NUM_OPERANDS; gi++) begin : g_seg
            gessm_segment #(
                .N(N),
                .M(M),
                .Q(Q)
            ) u_seg (
                .i_x      (w_op[gi]),
                .i_signed (in_signed),
                .o_win    (w_win[gi]),
                .o_seg    (w_seg[gi])
            );
        end
    endgenerate

    logic w_s1_neg;
    logic w_s1_exact;

    always_comb begin
        w_s1_neg   = in_signed && (in_a[N-1] ^ in_b[N-1]);
        w_s1_exact = (w_seg[0] == SEG_LOW) && (w_seg[1] == SEG_LOW);
    end

    logic             r_s1_valid;
    logic [M-1:0]     r_s1_win [NUM_OPERANDS];
    seg_e             r_s1_seg [NUM_OPERANDS];
    logic             r_s1_neg;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s1_exact;

    generate
        for (genvar gi = 0; gi < NUM_OPERANDS; gi++) begin : g_s1_ops
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s1_win[gi] <= '0;
                    r_s1_seg[gi] <= SEG_LOW;
                end else if (w_advance) begin
                    r_s1_win[gi] <= w_win[gi];
                    r_s1_seg[gi] <= w_seg[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_neg   <= 1'b0;
            r_s1_tag   <= '0;
            r_s1_exact <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            r_s1_neg   <= w_s1_neg;
            r_s1_tag   <= in_tag;
            r_s1_exact <= w_s1_exact;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: unsigned MxM core product.
    // ------------------------------------------------------------------
    logic [2*M-1:0] w_s2_prod;

    always_comb begin
        w_s2_prod = {{M{1'b0}}, r_s1_win[0]} * {{M{1'b0}}, r_s1_win[1]};
    end

    logic             r_s2_valid;
    logic [2*M-1:0]   r_s2_prod;
    seg_e             r_s2_seg_a;
    seg_e             r_s2_seg_b;
    logic             r_s2_neg;
    logic [TAG_W-1:0] r_s2_tag;
    logic             r_s2_exact;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_prod  <= '0;
            r_s2_seg_a <= SEG_LOW;
            r_s2_seg_b <= SEG_LOW;
            r_s2_neg   <= 1'b0;
            r_s2_tag   <= '0;
            r_s2_exact <= 1'b0;
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            r_s2_prod  <= w_s2_prod;
            r_s2_seg_a <= r_s1_seg[0];
            r_s2_seg_b <= r_s1_seg[1];
            r_s2_neg   <= r_s1_neg;
            r_s2_tag   <= r_s1_tag;
            r_s2_exact <= r_s1_exact;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: realign and sign. The largest shift is 2(N-M), so the
    // 2M-bit product always fits in 2N bits without overflow.
    // ------------------------------------------------------------------
    logic [2*N-1:0] w_s3_res;
    logic [2*N-1:0] w_s3_ris;
    int             w_s3_shamt;

    always_comb begin
        w_s3_shamt = seg_shift(r_s2_seg_a, N, M, Q) + seg_shift(r_s2_seg_b, N, M, Q);
        w_s3_res   = {{(2*N-2*M){1'b0}}, r_s2_prod} << w_s3_shamt;
        // Two's-complement negate; a zero product stays zero.
        w_s3_ris   = r_s2_neg ? (-w_s3_res) : w_s3_res;
    end

    logic [2*N-1:0]   r_out_ris;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_exact;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_ris   <= '0;
            r_out_tag   <= '0;
            r_out_exact <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= r_s2_valid;
            r_out_ris   <= w_s3_ris;
            r_out_tag   <= r_s2_tag;
            r_out_exact <= r_s2_exact;
        end
    end

    assign out_valid = r_out_valid;
    assign out_ris   = r_out_ris;
    assign out_tag   = r_out_tag;
    assign out_exact = r_out_exact;

endmodule

// File: tb/tb_gessm_mult_pipe.sv
// Testbench for gessm_mult_pipe: directed vector table with latency check,
// backpressure and mid-stream reset sequences, and randomized traffic
// checked against an arithmetic reference model through a scoreboard.
module tb_gessm_mult_pipe;

    localparam int N     = 16;
    localparam int M     = 8;
    localparam int Q     = 5;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             in_signed;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_ris;
    logic [TAG_W-1:0] out_tag;
    logic             out_exact;

    gessm_mult_pipe #(
        .N(N), .M(M), .Q(Q), .TAG_W(TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ris   (out_ris),
        .out_tag   (out_tag),
        .out_exact (out_exact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*N-1:0]   ris;
        logic [TAG_W-1:0] tag;
        logic             exact;
    } exp_t;

    typedef struct {
        logic [N-1:0]     a;
        logic [N-1:0]     b;
        logic             sgn;
        logic [TAG_W-1:0] tag;
        logic [2*N-1:0]   ris;
        logic             exact;
    } vec_t;

    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    bit               held   = 0;
    logic [2*N-1:0]   h_ris;
    logic [TAG_W-1:0] h_tag;
    logic             h_exact;

    // Reference: take |x|, keep the top M significant-window bits by plain
    // range comparison, multiply, scale back up, re-apply the sign mod 2^2N.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic sgn, input logic [TAG_W-1:0] tag);
        longint ma, mb, sa, sbb, prod;
        bit     neg;
        exp_t   e;
        ma  = (sgn && a[N-1]) ? (longint'(1) << N) - longint'(a) : longint'(a);
        mb  = (sgn && b[N-1]) ? (longint'(1) << N) - longint'(b) : longint'(b);
        sa  = (ma >= (longint'(1) << (M+Q))) ? N-M : (ma >= (longint'(1) << M)) ? Q : 0;
        sbb = (mb >= (longint'(1) << (M+Q))) ? N-M : (mb >= (longint'(1) << M)) ? Q : 0;
        prod = ((ma >> sa) * (mb >> sbb)) << (sa + sbb);
        neg  = sgn && (a[N-1] ^ b[N-1]);
        e.ris   = (2*N)'(neg ? -prod : prod);
        e.tag   = tag;
        e.exact = (sa == 0) && (sbb == 0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got ris=%h tag=%0d with no op outstanding", out_ris, out_tag);
            return;
        end
        e = exp_q.pop_front();
        if (out_ris !== e.ris || out_tag !== e.tag || out_exact !== e.exact) begin
            errors++;
            $display("FAIL result: got ris=%h tag=%0d exact=%0b, expected ris=%h tag=%0d exact=%0b",
                     out_ris, out_tag, out_exact, e.ris, e.tag, e.exact);
        end else begin
            $display("txn ok  ris=%h tag=%0d exact=%0b", out_ris, out_tag, out_exact);
        end
    endtask

    // One clock of scoreboard-driven traffic; inputs are set by the caller
    // before the call and observed at the falling edge.
    task automatic tick();
        @(negedge clk);
        if (held) begin
            checks++;
            if (out_valid !== 1'b1 || out_ris !== h_ris || out_tag !== h_tag || out_exact !== h_exact) begin
                errors++;
                $display("FAIL hold: got v=%0b ris=%h tag=%0d, expected v=1 ris=%h tag=%0d",
                         out_valid, out_ris, out_tag, h_ris, h_tag);
            end
        end
        if (out_valid && !out_ready) begin
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            held    = 1;
            h_ris   = out_ris;
            h_tag   = out_tag;
            h_exact = out_exact;
        end else begin
            held = 0;
        end
        if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_signed, in_tag));
        if (out_valid && out_ready) check_out();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard     = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 40) begin
            tick();
            guard++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [N-1:0] rand_op();
        logic [N-1:0] corners [4];
        corners[0] = 16'h8000;
        corners[1] = 16'hFFFF;
        corners[2] = 16'h0000;
        corners[3] = 16'h2000;
        if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 3)];
        return N'($urandom >> $urandom_range(0, 24));
    endfunction

    task automatic set_rand_op();
        in_a      = rand_op();
        in_b      = rand_op();
        in_signed = 1'($urandom_range(0, 1));
        in_tag    = TAG_W'($urandom);
    endtask

    vec_t vt [10];

    initial begin
        int lat;
        int sent;
        int stall_cnt;
        int guard;

        vt[0] = '{16'd200,  16'd100,  1'b0, 4'd3,  32'h00004E20, 1'b1};
        vt[1] = '{16'h1234, 16'd3,    1'b0, 4'd5,  32'h00003660, 1'b0};
        vt[2] = '{16'hFFFF, 16'hFFFF, 1'b0, 4'd7,  32'hFE010000, 1'b0};
        vt[3] = '{16'hFF38, 16'd100,  1'b1, 4'd9,  32'hFFFFB1E0, 1'b1};
        vt[4] = '{16'h8000, 16'h8000, 1'b1, 4'hA,  32'h40000000, 1'b0};
        vt[5] = '{16'h0000, 16'h8000, 1'b1, 4'hF,  32'h00000000, 1'b0};
        vt[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 4'd1,  32'h00000001, 1'b1};
        vt[7] = '{16'hFFFF, 16'd2,    1'b1, 4'd2,  32'hFFFFFFFE, 1'b1};
        vt[8] = '{16'h2000, 16'd1,    1'b0, 4'd4,  32'h00002000, 1'b0};
        vt[9] = '{16'h1FFF, 16'd1,    1'b0, 4'd6,  32'h00001FE0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ris",   64'(out_ris),   64'd0);
        chk("rst_out_tag",   64'(out_tag),   64'd0);
        chk("rst_out_exact", 64'(out_exact), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // Directed table: one op at a time, measuring latency.
        for (int i = 0; i < 10; i++) begin
            in_a      = vt[i].a;
            in_b      = vt[i].b;
            in_signed = vt[i].sgn;
            in_tag    = vt[i].tag;
            in_valid  = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 8) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
            chk($sformatf("vec%0d_ris", i),     64'(out_ris),   64'(vt[i].ris));
            chk($sformatf("vec%0d_tag", i),     64'(out_tag),   64'(vt[i].tag));
            chk($sformatf("vec%0d_exact", i),   64'(out_exact), 64'(vt[i].exact));
            $display("txn vec%0d a=%h b=%h s=%0b -> ris=%h tag=%0d exact=%0b lat=%0d",
                     i, vt[i].a, vt[i].b, vt[i].sgn, out_ris, out_tag, out_exact, lat);
            @(posedge clk);
            #1;
        end

        // Backpressure: 5 back-to-back ops, stall the first result 4 cycles.
        sent      = 0;
        stall_cnt = 0;
        guard     = 0;
        while (sent < 5 && guard < 50) begin
            in_a      = 16'h0100 + 16'(sent * 16'h0321);
            in_b      = 16'd7 + 16'(sent);
            in_signed = sent[0];
            in_tag    = TAG_W'(sent + 8);
            in_valid  = 1'b1;
            if (out_valid && stall_cnt < 4) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
            end
            if (in_ready) sent++;
            tick();
            guard++;
        end
        chk("bp_all_sent", 64'(sent), 64'd5);
        chk("bp_stalled",  64'(stall_cnt), 64'd4);
        drain();

        // Reset mid-stream: in-flight ops must vanish.
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_rand_op();
            in_valid = 1'b1;
            tick();
        end
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_ris",   64'(out_ris),   64'd0);
        chk("async_rst_tag",   64'(out_tag),   64'd0);
        exp_q.delete();
        held     = 0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) tick();
        chk("post_reset_no_stale", 64'(out_valid), 64'd0);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            set_rand_op();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
